// File: rtl/wallace_product_accumulator.sv
// Sums COUNT consecutive unsigned products from the Wallace tree multiplier and hands off the total.
// Optional build macro WALLACE_ACC_SATURATE_EN clamps on carry-out instead of wrapping.
module wallace_product_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned COUNT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [SUM_W-1:0]   sum_c;
    logic               carry_c;
    logic [ACC_W-1:0]   beat_acc_c;
    logic               last_c;

    // Widened adder: the extra bit is the carry-out that drives overflow
    always_comb begin
        sum_c   = {1'b0, acc_q} + SUM_W'(prod);
        carry_c = sum_c[ACC_W];
        last_c  = (cnt_q == CNT_W'(COUNT - 1));
`ifdef WALLACE_ACC_SATURATE_EN
        beat_acc_c = carry_c ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
        beat_acc_c = sum_c[ACC_W-1:0];
`endif
    end

    // Next-state and datapath update; clear overrides everything
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = beat_acc_c;
                        ovf_d = ovf_q | carry_c;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (last_c) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (start) begin
                            state_d = ACCUM;
                            acc_d   = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode the state register only, never the inputs
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign acc_sum   = acc_q;
    assign overflow  = ovf_q;

endmodule
